spi_apb_regs: RTL and testbench

SPI_APB_REGS -- requirements
Module: spi_apb_regs

---
 rtl/spi_apb_regs_if.sv | 19 +
 rtl/spi_apb_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_apb_regs.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_apb_regs_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_apb_regs_if
//   APB slave bus bundle used by spi_apb_regs.
//   Revision: 1.0
// ---------------------------------------------------------------------------
interface spi_apb_regs_if;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        pen;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output paddr, pwrite, psel, pen, pwdata, input prdata, pready);
  modport slave  (input paddr, pwrite, psel, pen, pwdata, output prdata, pready);
endinterface
`default_nettype wire

// File: rtl/spi_apb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_apb_regs
//   APB register front end for an SPI engine: command register with a
//   launch FSM, TX/RX byte FIFOs and sticky status flags.
//   Optional feature macro: SPI_APB_IRQ_EN (adds done_flag and irq output).
//   Revision: 1.0
// ---------------------------------------------------------------------------
module spi_apb_regs #(
  parameter int FIFO_AW = 5
) (
  input  wire           clk,
  input  wire           rst,
  spi_apb_regs_if.slave apb,
  output logic          eng_start,
  output logic [7:0]    eng_cmd,
  input  wire           eng_done,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  wire           tx_ready,
  input  wire  [7:0]    rx_data,
  input  wire           rx_valid
`ifdef SPI_APB_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            alive_q, alive_d;
  logic [7:0]      tx_mem_q [DEPTH];
  logic [7:0]      tx_mem_d [DEPTH];
  logic [7:0]      rx_mem_q [DEPTH];
  logic [7:0]      rx_mem_d [DEPTH];
  logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic            rx_ovf_q, rx_ovf_d, rx_unf_q, rx_unf_d;

  logic [1:0]      addr;
  logic            access, stall, busy;
  logic            cmd_wr, tx_push, tx_pop, rx_push, rx_pop, rx_rd, status_rd;
  logic            ovf_evt, unf_evt, done_bit;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [PW-1:0]   tx_count, rx_count;
  logic [7:0]      rx_head;
  logic [31:0]     status_word, rdata;
  logic            unused_apb_bits;

  assign unused_apb_bits = ^{apb.paddr[31:2], apb.pwdata[31:9]};

  // FIFO occupancy from wrap-around pointers (extra MSB separates full from empty)
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                    (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign rx_count = rx_wr_q - rx_rd_q;
  assign rx_head  = rx_mem_q[rx_rd_q[FIFO_AW-1:0]];

  // APB decode; alive_q keeps the bus quiet until the first clock after reset
  assign addr   = apb.paddr[1:0];
  assign busy   = (state_q != S_IDLE);
  assign access = alive_q && apb.psel && apb.pen;
  // CMD writes wait for the FSM to go idle so eng_cmd never changes mid-command;
  // TXDATA writes wait for a free slot.
  assign stall  = apb.pwrite && (((addr == ADDR_CMD) && busy) ||
                                 ((addr == ADDR_TXDATA) && tx_full));
  assign apb.pready = access && !stall;

  assign cmd_wr    = apb.pready &&  apb.pwrite && (addr == ADDR_CMD);
  assign tx_push   = apb.pready &&  apb.pwrite && (addr == ADDR_TXDATA);
  assign rx_rd     = apb.pready && !apb.pwrite && (addr == ADDR_RXDATA);
  assign status_rd = apb.pready && !apb.pwrite && (addr == ADDR_STATUS);
  assign rx_pop    = rx_rd && !rx_empty;
  assign unf_evt   = rx_rd &&  rx_empty;
  assign tx_pop    = tx_valid && tx_ready;
  // A full RX FIFO still accepts a byte when the APB side pops in the same cycle.
  assign rx_push   = rx_valid && (!rx_full || rx_pop);
  assign ovf_evt   = rx_valid && rx_full && !rx_pop;

  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_mem_q[tx_rd_q[FIFO_AW-1:0]];
  assign eng_start = (state_q == S_LAUNCH);
  assign eng_cmd   = cmd_q;
  assign apb.prdata = rdata;

  // Status word assembly and zero-wait read mux
  always_comb begin
    status_word        = '0;
    status_word[0]     = busy;
    status_word[1]     = tx_full;
    status_word[2]     = tx_empty;
    status_word[3]     = rx_full;
    status_word[4]     = rx_empty;
    status_word[5]     = rx_ovf_q;
    status_word[6]     = rx_unf_q;
    status_word[7]     = done_bit;
    status_word[13:8]  = 6'(tx_count);
    status_word[21:16] = 6'(rx_count);
    rdata = '0;
    if (access && !apb.pwrite) begin
      case (addr)
        ADDR_CMD:    rdata = {24'b0, cmd_q};
        ADDR_STATUS: rdata = status_word;
        ADDR_RXDATA: rdata = rx_empty ? 32'd0 : {24'b0, rx_head};
        default:     rdata = '0;
      endcase
    end
  end

  // Command register and launch FSM next state
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    alive_d = 1'b1;
    if (cmd_wr) cmd_d = apb.pwdata[7:0];
    case (state_q)
      S_IDLE:   if (cmd_wr && apb.pwdata[8]) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN:    if (eng_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO storage and pointer updates
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q[FIFO_AW-1:0]] = apb.pwdata[7:0];
    if (rx_push) rx_mem_d[rx_wr_q[FIFO_AW-1:0]] = rx_data;
    tx_wr_d = tx_wr_q + PW'(tx_push);
    tx_rd_d = tx_rd_q + PW'(tx_pop);
    rx_wr_d = rx_wr_q + PW'(rx_push);
    rx_rd_d = rx_rd_q + PW'(rx_pop);
  end

  // Sticky flags: a STATUS read clears them, a same-cycle event wins
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (status_rd) begin
      rx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (ovf_evt) rx_ovf_d = 1'b1;
    if (unf_evt) rx_unf_d = 1'b1;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      alive_q  <= 1'b0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      alive_q  <= alive_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_ovf_q <= rx_ovf_d;
      rx_unf_q <= rx_unf_d;
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
    end
  end

`ifdef SPI_APB_IRQ_EN
  logic done_flag_q, done_flag_d, irq_q, irq_d;

  // done_flag tracks accepted eng_done; irq is its registered OR with rx_ovf
  always_comb begin
    done_flag_d = done_flag_q;
    if (status_rd) done_flag_d = 1'b0;
    if ((state_q == S_RUN) && eng_done) done_flag_d = 1'b1;
    irq_d = done_flag_q || rx_ovf_q;
  end

  // Interrupt-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_flag_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      done_flag_q <= done_flag_d;
      irq_q       <= irq_d;
    end
  end

  assign done_bit = done_flag_q;
  assign irq      = irq_q;
`else
  assign done_bit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_apb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_apb_regs
//   Directed corner cases plus randomized traffic for spi_apb_regs, checked
//   against a queue-based reference model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_apb_regs;
  localparam int DEPTH      = 32;
  localparam int WAIT_LIMIT = 200;
  localparam logic [1:0] A_CMD = 2'd0, A_STATUS = 2'd1, A_TXDATA = 2'd2, A_RXDATA = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       eng_start;
  logic [7:0] eng_cmd;
  logic       eng_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
`ifdef SPI_APB_IRQ_EN
  logic       irq;
`endif

  spi_apb_regs_if apb();

  spi_apb_regs #(.FIFO_AW(5)) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_done(eng_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_APB_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte queues plus abstract command/flag state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_cmd;
  bit m_busy, m_launch, m_ovf, m_unf, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    tx_q.delete(); rx_q.delete();
    m_cmd = 8'h00; m_busy = 0; m_launch = 0; m_ovf = 0; m_unf = 0; m_done = 0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = m_busy;
    s[1] = (tx_q.size() == DEPTH);
    s[2] = (tx_q.size() == 0);
    s[3] = (rx_q.size() == DEPTH);
    s[4] = (rx_q.size() == 0);
    s[5] = m_ovf;
    s[6] = m_unf;
    s[7] = m_done;
    s[13:8]  = 6'(tx_q.size());
    s[21:16] = 6'(rx_q.size());
    return s;
  endfunction

  function automatic logic [31:0] rnd_addr(input logic [1:0] a);
    logic [31:0] r;
    r = $urandom();
    r[1:0] = a;
    return r;
  endfunction

  // One APB transfer: SETUP, then ACCESS until pready (bounded)
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits);
    apb.psel = 1'b1; apb.pen = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
    @(posedge clk); #1;
    apb.pen = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!apb.pready && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= WAIT_LIMIT) check("pready_timeout", 32'(apb.pready), 32'd1);
    rdata = apb.prdata;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.pen = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic cmd_write(input logic [8:0] v);
    logic [31:0] d, rd;
    int w;
    d = $urandom();
    d[8:0] = v;
    apb_xfer(1'b1, rnd_addr(A_CMD), d, rd, w);
    check("cmd_wr_wait", 32'(w), 32'd0);
    m_cmd = v[7:0];
    if (v[8]) begin m_busy = 1; m_launch = 1; end
    check("eng_start_after_cmd", 32'(eng_start), 32'(v[8]));
    check("eng_cmd_after_cmd", 32'(eng_cmd), 32'(m_cmd));
  endtask

  task automatic cmd_read(input string tag);
    logic [31:0] rd;
    int w;
    apb_xfer(1'b0, rnd_addr(A_CMD), $urandom(), rd, w);
    check(tag, rd, {24'b0, m_cmd});
  endtask

  task automatic status_read(input string tag);
    logic [31:0] rd;
    int w;
    apb_xfer(1'b0, rnd_addr(A_STATUS), $urandom(), rd, w);
    check(tag, rd, exp_status());
    m_ovf = 0; m_unf = 0; m_done = 0;
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] rd, exp;
    int w;
    apb_xfer(1'b0, rnd_addr(A_RXDATA), $urandom(), rd, w);
    exp = (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'd0;
    check(tag, rd, exp);
    check("rx_rd_wait", 32'(w), 32'd0);
    if (rx_q.size() != 0) void'(rx_q.pop_front());
    else m_unf = 1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    logic [31:0] d, rd;
    int w;
    d = $urandom();
    d[7:0] = b;
    apb_xfer(1'b1, rnd_addr(A_TXDATA), d, rd, w);
    check("tx_wr_wait", 32'(w), 32'd0);
    tx_q.push_back(b);
  endtask

  task automatic ignored_access();
    logic [31:0] rd;
    int w, k;
    k = $urandom_range(0, 2);
    if (k == 0) apb_xfer(1'b1, rnd_addr(A_STATUS), $urandom(), rd, w);
    else if (k == 1) apb_xfer(1'b1, rnd_addr(A_RXDATA), $urandom(), rd, w);
    else begin
      apb_xfer(1'b0, rnd_addr(A_TXDATA), $urandom(), rd, w);
      check("txdata_read_zero", rd, 32'd0);
    end
    check("ignored_wait", 32'(w), 32'd0);
  endtask

  // One engine-side cycle with the APB bus idle
  task automatic eng_cycle(input bit txr, input bit rxv, input logic [7:0] rxd, input bit done);
    tx_ready = txr; rx_valid = rxv; rx_data = rxd; eng_done = done;
    @(negedge clk);
    check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check("eng_start_pulse", 32'(eng_start), 32'(m_launch));
    @(posedge clk); #1;
    tx_ready = 1'b0; rx_valid = 1'b0; eng_done = 1'b0;
    if (txr && tx_q.size() != 0) void'(tx_q.pop_front());
    if (rxv) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(rxd);
      else m_ovf = 1;
    end
    if (done && m_busy && !m_launch) begin
      m_busy = 0;
`ifdef SPI_APB_IRQ_EN
      m_done = 1;
`endif
    end
    m_launch = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int w;
    logic [7:0] popped;
    logic [7:0] b33;

    rst = 1'b0;
    apb.psel = 0; apb.pen = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    eng_done = 0; tx_ready = 0; rx_valid = 0; rx_data = '0;
    model_reset();
    #12;
    apb.psel = 1; apb.pen = 1; apb.paddr = 32'h1;
    #1;
    check("rst_pready", 32'(apb.pready), 32'd0);
    check("rst_prdata", apb.prdata, 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_cmd", 32'(eng_cmd), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    apb.psel = 0; apb.pen = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    status_read("status_after_reset");
    cmd_read("cmd_after_reset");

    // RXDATA read on an empty FIFO
    rx_read("rx_empty_read");
    status_read("status_unf");

    // Overfill RX: 33 pushes, no reads
    for (int i = 0; i < 33; i++) eng_cycle(1'b0, 1'b1, 8'($urandom()), 1'b0);
    status_read("status_rx_ovf");
    status_read("status_ovf_cleared");

    // Overflow during a STATUS read: the set wins over the clear
    fork
      apb_xfer(1'b0, rnd_addr(A_STATUS), 32'd0, rd, w);
      begin @(posedge clk); #1; rx_valid = 1; rx_data = 8'hA5; @(posedge clk); #1; rx_valid = 0; end
    join
    check("status_race_read", rd, exp_status());
    m_ovf = 1;
    status_read("status_ovf_set_wins");

    // Full RX with simultaneous pop and push: no overflow
    fork
      apb_xfer(1'b0, rnd_addr(A_RXDATA), 32'd0, rd, w);
      begin @(posedge clk); #1; rx_valid = 1; rx_data = 8'h3C; @(posedge clk); #1; rx_valid = 0; end
    join
    check("rx_pop_full_data", rd, {24'b0, rx_q[0]});
    void'(rx_q.pop_front());
    rx_q.push_back(8'h3C);
    status_read("status_full_pop_push");
    for (int i = 0; i < DEPTH; i++) rx_read("rx_drain");

    // Fill TX, then a 33rd write stalls until one byte drains
    for (int i = 0; i < DEPTH; i++) tx_write(8'($urandom()));
    b33 = 8'($urandom());
    popped = 8'h00;
    fork
      apb_xfer(1'b1, rnd_addr(A_TXDATA), {24'b0, b33}, rd, w);
      begin
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(negedge clk) popped = tx_data;
        @(posedge clk); #1 tx_ready = 1'b0;
      end
    join
    check("tx_full_stall_waits", 32'(w), 32'd3);
    check("tx_popped_head", 32'(popped), 32'(tx_q[0]));
    void'(tx_q.pop_front());
    tx_q.push_back(b33);
    status_read("status_tx_full_after_stall");

    // Launch 0x188: one-cycle eng_start, busy until eng_done
    cmd_write(9'h188);
    eng_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    status_read("status_busy");
    eng_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    status_read("status_idle_after_done");

    // CMD write while busy stalls until eng_done, then relaunches
    cmd_write(9'h155);
    eng_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    fork
      apb_xfer(1'b1, rnd_addr(A_CMD), 32'h0000_0103, rd, w);
      begin
        repeat (4) @(posedge clk);
        check("eng_cmd_stable_busy", 32'(eng_cmd), 32'h55);
        #1 eng_done = 1'b1;
        @(posedge clk); #1 eng_done = 1'b0;
      end
    join
    check("cmd_busy_stall_waits", 32'(w), 32'd4);
    m_cmd = 8'h03; m_busy = 1; m_launch = 1;
`ifdef SPI_APB_IRQ_EN
    m_done = 1;
`endif
    check("relaunch_eng_start", 32'(eng_start), 32'd1);
    check("relaunch_eng_cmd", 32'(eng_cmd), 32'h03);
    // eng_done during LAUNCH is ignored
    eng_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    status_read("status_busy_after_launch_done");
    eng_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    status_read("status_idle_after_relaunch");

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: if (tx_q.size() < DEPTH) tx_write(8'($urandom()));
        2: rx_read("rx_rand");
        3: status_read("status_rand");
        4: if (!m_busy) begin
             cmd_write(9'($urandom()));
             eng_cycle(1'b0, 1'b0, 8'h00, 1'b0);
           end
        5: cmd_read("cmd_rand");
        6: ignored_access();
        default: eng_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()),
                           m_busy && ($urandom_range(0, 3) == 0));
      endcase
    end

    // Reset in the middle of a launch with 5 TX bytes queued
    if (m_busy) eng_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    while (tx_q.size() != 0) eng_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (5) tx_write(8'($urandom()));
    cmd_write(9'h1AA);
    #2 rst = 1'b0;
    apb.psel = 1; apb.pen = 1; apb.pwrite = 0; apb.paddr = 32'h1;
    #1;
    check("midrun_rst_eng_start", 32'(eng_start), 32'd0);
    check("midrun_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrun_rst_eng_cmd", 32'(eng_cmd), 32'd0);
    check("midrun_rst_pready", 32'(apb.pready), 32'd0);
    check("midrun_rst_prdata", apb.prdata, 32'd0);
    apb.psel = 0; apb.pen = 0;
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    status_read("status_after_midrun_reset");
    cmd_read("cmd_after_midrun_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
